// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle add/sub/logic, iterative shift-add MUL
// and restoring DIV sharing one hi/lo working register pair.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  input  logic             div_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             dbz,
  output logic             zero,
  output logic             sign,
  output logic             parity
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
  logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;
  logic             mul_reg, mul_next, qneg_reg, qneg_next, dovf_reg, dovf_next;

  logic [WIDTH-1:0] out_reg, res_out;
  logic             carry_reg, ovf_reg, dbz_reg, zero_reg, sign_reg, parity_reg;
  logic             res_carry, res_ovf, res_dbz, load, accept;

  logic [WIDTH:0]   add_sum, sub_diff, mul_sum, div_shift, div_trial, mul_top;
  logic [WIDTH-1:0] a_mag, b_mag, mul_hi_nx, mul_lo_nx, mul_h;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx, div_q;
  logic             div_ok;

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign a_mag    = (div_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag    = (div_signed && b[WIDTH-1]) ? -b : b;

  // MUL: hi:lo holds partial product : remaining multiplier bits, shifted right each step.
  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], lo_reg[WIDTH-1:1]};
  // Signed high half of the product, derived from the unsigned one.
  assign mul_h     = mul_hi_nx - (a_reg[WIDTH-1] ? b_reg : '0) - (b_reg[WIDTH-1] ? a_reg : '0);
  assign mul_top   = {mul_h, mul_lo_nx[WIDTH-1]};

  // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_reg};
  assign div_ok    = ~div_trial[WIDTH];
  assign div_hi_nx = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_nx = {lo_reg[WIDTH-2:0], div_ok};
  assign div_q     = qneg_reg ? -div_lo_nx : div_lo_nx;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    mul_next   = mul_reg;
    qneg_next  = qneg_reg;
    dovf_next  = dovf_reg;
    load       = 1'b0;
    res_out    = '0;
    res_carry  = 1'b0;
    res_ovf    = 1'b0;
    res_dbz    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          a_next     = a;
          b_next     = b;
          hi_next    = '0;
          cnt_next   = '0;
          state_next = DONE;
          load       = 1'b1;
          case (select)
            3'd0: begin
              res_out   = add_sum[WIDTH-1:0];
              res_carry = add_sum[WIDTH];
              res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
              res_out   = sub_diff[WIDTH-1:0];
              res_carry = sub_diff[WIDTH];
              res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: begin
              load       = 1'b0;
              state_next = CALC;
              mul_next   = 1'b1;
              lo_next    = b;
            end
            3'd3: begin
              load       = 1'b0;
              state_next = CALC;
              mul_next   = 1'b0;
              lo_next    = a_mag;
              b_next     = b_mag;
              qneg_next  = div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              dovf_next  = div_signed && (a == MIN) && (&b);
            end
            3'd4:    res_out = a & b;
            3'd5:    res_out = a | b;
            3'd6:    res_out = a ^ b;
            default: res_out = ~a;
          endcase
        end
      end
      CALC: begin
        cnt_next = cnt_reg + 1'b1;
        hi_next  = mul_reg ? mul_hi_nx : div_hi_nx;
        lo_next  = mul_reg ? mul_lo_nx : div_lo_nx;
        if (cnt_reg == LAST) begin
          load       = 1'b1;
          state_next = DONE;
          if (mul_reg) begin
            res_out   = mul_lo_nx;
            res_carry = |mul_hi_nx;
            res_ovf   = !((&mul_top) || !(|mul_top));
          end else begin
            res_dbz = (b_reg == '0);
            res_out = res_dbz ? '1 : div_q;
            res_ovf = res_dbz || dovf_reg;
          end
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      mul_reg    <= 1'b0;
      qneg_reg   <= 1'b0;
      dovf_reg   <= 1'b0;
      out_reg    <= '0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      dbz_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      sign_reg   <= 1'b0;
      parity_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      mul_reg   <= mul_next;
      qneg_reg  <= qneg_next;
      dovf_reg  <= dovf_next;
      if (load) begin
        out_reg    <= res_out;
        carry_reg  <= res_carry;
        ovf_reg    <= res_ovf;
        dbz_reg    <= res_dbz;
        zero_reg   <= (res_out == '0);
        sign_reg   <= res_out[WIDTH-1];
        parity_reg <= ~^res_out;
      end
    end
  end

  assign out      = out_reg;
  assign carry    = carry_reg;
  assign overflow = ovf_reg;
  assign dbz      = dbz_reg;
  assign zero     = zero_reg;
  assign sign     = sign_reg;
  assign parity   = parity_reg;
endmodule
